// File: rtl/enc_seq_scan.sv
// enc_seq_scan: sequential priority encoder.
// Captures an N-bit request vector and returns the binary index of each
// set bit, highest index first. One index is returned per accepted transfer,
// using a valid/ready handshake on the output side.
//
// Ports
//   clock_i   rising-edge clock
//   resetn_i  asynchronous active-low reset; clears all state and outputs
//   load_i    capture request, only honoured while busy_o=0
//   r_i       request vector, r_i[N-1] has the highest priority
//   ready_i   consumer takes y_o this cycle
//   busy_o    a captured vector is being emitted
//   valid_o   y_o holds a valid index
//   y_o       index of the highest pending bit (0 when not valid)
//   last_o    y_o is the final pending bit (0 when not valid)
//   z_o       one-cycle pulse after an all-zero vector was loaded
//   count_o   popcount of the most recently captured vector
//
// state | meaning
// IDLE  | nothing pending, waiting for load_i
// EMIT  | pending bits left, presenting the highest one on y_o

module enc_seq_scan #(
  parameter int N = 8,
  parameter int W = 3   // N must equal 2**W
) (
  input  logic         clock_i,
  input  logic         resetn_i,
  input  logic         load_i,
  input  logic [N-1:0] r_i,
  input  logic         ready_i,
  output logic         busy_o,
  output logic         valid_o,
  output logic [W-1:0] y_o,
  output logic         last_o,
  output logic         z_o,
  output logic [W:0]   count_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  state_e         state_q;
  logic [N-1:0]   p_q;
  logic [W-1:0]   y_q;
  logic           last_q;
  logic           z_q;
  logic [W:0]     count_q;

  logic [N-1:0]   p_d;
  logic [W-1:0]   load_idx_d;
  logic [W:0]     load_pop_d;
  logic [W-1:0]   next_idx_d;
  logic [W:0]     next_pop_d;

  // Highest set bit wins because the loop scans upward and keeps overwriting.
  function automatic logic [W-1:0] hi_idx(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) idx = i[W-1:0];
    end
    return idx;
  endfunction

  function automatic logic [W:0] pop_cnt(input logic [N-1:0] v);
    logic [W:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + {{W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Pending set after the currently presented bit has been consumed.
  assign p_d        = p_q & ~({{(N-1){1'b0}}, 1'b1} << y_q);
  assign load_idx_d = hi_idx(r_i);
  assign load_pop_d = pop_cnt(r_i);
  assign next_idx_d = hi_idx(p_d);
  assign next_pop_d = pop_cnt(p_d);

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      y_q     <= '0;
      last_q  <= 1'b0;
      z_q     <= 1'b0;
      count_q <= '0;
    end else begin
      z_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load_i) begin
            count_q <= load_pop_d;
            if (r_i != '0) begin
              state_q <= ST_EMIT;
              p_q     <= r_i;
              y_q     <= load_idx_d;
              last_q  <= (load_pop_d == {{W{1'b0}}, 1'b1});
            end else begin
              z_q <= 1'b1;
            end
          end
        end
        ST_EMIT: begin
          // load_i/r_i are deliberately not looked at here, even on the
          // final transfer, so a new vector always costs one idle cycle.
          if (ready_i) begin
            if (last_q) begin
              state_q <= ST_IDLE;
              p_q     <= '0;
              y_q     <= '0;
              last_q  <= 1'b0;
            end else begin
              p_q    <= p_d;
              y_q    <= next_idx_d;
              last_q <= (next_pop_d == {{W{1'b0}}, 1'b1});
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          p_q     <= '0;
          y_q     <= '0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o  = (state_q == ST_EMIT);
  assign valid_o = (state_q == ST_EMIT);
  assign y_o     = y_q;
  assign last_o  = last_q;
  assign z_o     = z_q;
  assign count_o = count_q;

endmodule

// File: tb/tb_enc_seq_scan.sv
module tb_enc_seq_scan;

  logic       clk;
  logic       resetn;
  logic       load;
  logic [7:0] r;
  logic       ready;
  logic       busy;
  logic       valid;
  logic [2:0] y;
  logic       last;
  logic       z;
  logic [3:0] count;

  int tests = 0;
  int fails = 0;

  // Reference model: the pending bits as a queue of indices, highest first.
  int q_m[$];
  int cnt_m = 0;
  bit z_m   = 0;

  typedef struct {
    logic       l;
    logic [7:0] r;
    logic       rdy;
    logic       busy;
    logic [2:0] y;
    logic       last;
    logic       z;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl[13];

  enc_seq_scan #(.N(8), .W(3)) dut (
    .clock_i (clk),
    .resetn_i(resetn),
    .load_i  (load),
    .r_i     (r),
    .ready_i (ready),
    .busy_o  (busy),
    .valid_o (valid),
    .y_o     (y),
    .last_o  (last),
    .z_o     (z),
    .count_o (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q_m.delete();
    cnt_m = 0;
    z_m   = 0;
  endtask

  task automatic model_step(input logic l, input logic [7:0] rv, input logic rdy);
    z_m = 0;
    if (q_m.size() > 0) begin
      if (rdy) q_m.delete(0);
    end else if (l) begin
      if (rv == 8'h00) begin
        z_m   = 1;
        cnt_m = 0;
      end else begin
        for (int i = 7; i >= 0; i--) if (rv[i]) q_m.push_back(i);
        cnt_m = q_m.size();
      end
    end
  endtask

  task automatic check_model(input string tag);
    int ey;
    int el;
    ey = (q_m.size() > 0) ? q_m[0] : 0;
    el = (q_m.size() == 1) ? 1 : 0;
    chk({tag, ".busy"},  int'(busy),  (q_m.size() > 0) ? 1 : 0);
    chk({tag, ".valid"}, int'(valid), (q_m.size() > 0) ? 1 : 0);
    chk({tag, ".y"},     int'(y),     ey);
    chk({tag, ".last"},  int'(last),  el);
    chk({tag, ".z"},     int'(z),     int'(z_m));
    chk({tag, ".count"}, int'(count), cnt_m);
  endtask

  // Drive inputs (called just after a falling edge), clock once, sample at
  // the next falling edge and compare against the model.
  task automatic cycle(input string tag, input logic l, input logic [7:0] rv,
                       input logic rdy);
    load  = l;
    r     = rv;
    ready = rdy;
    @(posedge clk);
    model_step(l, rv, rdy);
    @(negedge clk);
    check_model(tag);
  endtask

  function automatic vec_t mk(input logic l, input logic [7:0] rv, input logic rdy,
                              input logic b, input logic [2:0] ey, input logic el,
                              input logic ez, input logic [3:0] ec);
    vec_t v;
    v.l = l; v.r = rv; v.rdy = rdy; v.busy = b;
    v.y = ey; v.last = el; v.z = ez; v.cnt = ec;
    return v;
  endfunction

  initial begin
    tbl[0]  = mk(1, 8'hA4, 1, 1, 3'd7, 0, 0, 4'd3);
    tbl[1]  = mk(0, 8'h00, 1, 1, 3'd5, 0, 0, 4'd3);
    tbl[2]  = mk(0, 8'h00, 1, 1, 3'd2, 1, 0, 4'd3);
    tbl[3]  = mk(0, 8'h00, 1, 0, 3'd0, 0, 0, 4'd3);
    tbl[4]  = mk(1, 8'h00, 1, 0, 3'd0, 0, 1, 4'd0);
    tbl[5]  = mk(0, 8'h00, 1, 0, 3'd0, 0, 0, 4'd0);
    tbl[6]  = mk(1, 8'h81, 0, 1, 3'd7, 0, 0, 4'd2);
    tbl[7]  = mk(0, 8'h00, 0, 1, 3'd7, 0, 0, 4'd2);
    tbl[8]  = mk(0, 8'h00, 0, 1, 3'd7, 0, 0, 4'd2);
    tbl[9]  = mk(0, 8'h00, 0, 1, 3'd7, 0, 0, 4'd2);
    tbl[10] = mk(0, 8'h00, 0, 1, 3'd7, 0, 0, 4'd2);
    tbl[11] = mk(0, 8'h00, 1, 1, 3'd0, 1, 0, 4'd2);
    tbl[12] = mk(0, 8'h00, 1, 0, 3'd0, 0, 0, 4'd2);

    resetn = 1'b0;
    load   = 1'b0;
    r      = 8'h00;
    ready  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_model("reset");
    resetn = 1'b1;

    // Directed table: 8'hA4 scan, zero vector, stalled 8'h81.
    for (int i = 0; i < 13; i++) begin
      string tg;
      tg = $sformatf("tbl%0d", i);
      cycle(tg, tbl[i].l, tbl[i].r, tbl[i].rdy);
      chk({tg, ".tbusy"},  int'(busy),  int'(tbl[i].busy));
      chk({tg, ".tvalid"}, int'(valid), int'(tbl[i].busy));
      chk({tg, ".ty"},     int'(y),     int'(tbl[i].y));
      chk({tg, ".tlast"},  int'(last),  int'(tbl[i].last));
      chk({tg, ".tz"},     int'(z),     int'(tbl[i].z));
      chk({tg, ".tcount"}, int'(count), int'(tbl[i].cnt));
    end

    // Load/R ignored while busy, including on the final transfer.
    begin
      int seen[$];
      cycle("f0", 1, 8'hF0, 1);
      if (valid) seen.push_back(int'(y));
      for (int i = 0; i < 4; i++) begin
        cycle("f0b", 1, 8'h0F, 1);
        if (valid) seen.push_back(int'(y));
      end
      chk("f0.nseen", seen.size(), 4);
      if (seen.size() == 4) begin
        chk("f0.seq0", seen[0], 7);
        chk("f0.seq3", seen[3], 4);
      end
      chk("f0.busy_after", int'(busy), 0);
      chk("f0.count", int'(count), 4);
      cycle("f0idle", 0, 8'h00, 1);
    end

    // All-ones vector: count needs the extra bit.
    cycle("ff", 1, 8'hFF, 1);
    chk("ff.count", int'(count), 8);
    for (int i = 0; i < 7; i++) cycle("ffrun", 0, 8'h00, 1);
    chk("ff.lasty", int'(y), 0);
    chk("ff.lastflag", int'(last), 1);
    cycle("ffend", 0, 8'h00, 1);

    // Asynchronous reset in the middle of an emission.
    cycle("ff2", 1, 8'hFF, 1);
    cycle("ff2", 0, 8'h00, 1);
    cycle("ff2", 0, 8'h00, 1);
    chk("ff2.y_before_rst", int'(y), 5);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst.busy",  int'(busy),  0);
    chk("arst.valid", int'(valid), 0);
    chk("arst.y",     int'(y),     0);
    chk("arst.last",  int'(last),  0);
    chk("arst.z",     int'(z),     0);
    chk("arst.count", int'(count), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    cycle("post_rst", 1, 8'h01, 1);
    chk("post_rst.y", int'(y), 0);
    chk("post_rst.last", int'(last), 1);
    chk("post_rst.count", int'(count), 1);
    cycle("post_rst_idle", 0, 8'h00, 1);

    // Back-to-back vectors with the mandatory idle cycle.
    cycle("b2b_a", 1, 8'h02, 1);
    chk("b2b_a.y", int'(y), 1);
    cycle("b2b_gap", 1, 8'h40, 1);
    chk("b2b_gap.valid", int'(valid), 0);
    cycle("b2b_b", 1, 8'h40, 1);
    chk("b2b_b.y", int'(y), 6);
    cycle("b2b_end", 0, 8'h00, 1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic       l;
      logic [7:0] rv;
      logic       rdy;
      l   = ($urandom_range(0, 2) == 0);
      rv  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      cycle("rand", l, rv, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/enc_seq_scan.md
# enc_seq_scan

Sequential priority encoder: captures an N-bit one-hot-or-multi-hot request vector and emits the binary index of each set bit, one per accepted transfer, highest index first. It is the inverse companion of the team's 2-to-4 decoder datapath: decoder outputs, or any request word, are turned back into binary codes for downstream logic. A valid/ready handshake on the output side allows a stalling consumer.

## Interface
- N, 8, request vector width; must equal 2^W
- W, 3, encoded index width
- Clock  in  1  rising-edge clock
- Resetn  in  1  asynchronous, active-low reset
- Load  in  1  capture request: sampled only when Busy=0
- R  in  N  request vector; R[N-1] has highest priority
- Ready  in  1  consumer accepts Y this cycle
- Busy  out  1  vector captured, emission in progress
- Valid  out  1  Y holds a valid index
- Y  out  W  binary index of highest-priority pending bit
- Last  out  1  Y is the final pending bit of the captured vector
- Z  out  1  one-cycle pulse: captured vector was all-zero
- Count  out  W+1  popcount of the last captured vector

## Operation
- Internal pending register P[N-1:0]; two states: IDLE, EMIT.
- IDLE: Busy=0, Valid=0, Y=0, Last=0.
  - Load=1, R!=0: P<=R, Count<=popcount(R), go EMIT.
  - Load=1, R==0: P stays 0, Count<=0, Z=1 for the next cycle only, stay IDLE.
  - Load=0: hold; Count keeps its previous value.
- EMIT: Busy=1, Valid=1.
  - Y = index of the highest set bit of P.
  - Last = 1 iff P has exactly one bit set.
  - Transfer occurs when Valid&&Ready at a rising edge. On transfer, clear P[Y]; if Last, P becomes 0 and the state returns to IDLE.
  - Ready=0: P, Y and Last are held stable; Valid stays 1.
  - Load and R are ignored while Busy=1, including the cycle of the final transfer.
- Count is W+1 bits wide so that all-ones (N set bits) is representable. Count is held until the next Load accepted in IDLE and does not decrement.
- Y and Last are 0 whenever Valid=0.
- Resetn=0 (asynchronous, any state): P=0, state=IDLE. All outputs are forced to 0 immediately: Busy, Valid, Y, Last, Z, Count.

## Timing
- Load-to-Valid latency: 1 cycle. Load is sampled at edge k; Valid=1 from edge k through the final transfer.
- Throughput: one index per cycle while Ready=1. A vector with m set bits, accepted at edge k with Ready held high, completes in m cycles; the final transfer occurs at edge k+m.
- Busy and Valid fall at the edge of the final transfer. The earliest following Load is sampled at the next edge, giving one idle cycle between vectors.
- Z is registered: it is high for exactly the one cycle after the edge at which a zero vector was loaded.
- Reset release: the state machine is in IDLE. The first Load is accepted at the first rising edge with Resetn=1.

## Test plan
- Reset; Load R=8'b1010_0100 with Ready=1 -> Count=3; Y=7,5,2 on three consecutive cycles; Last=1 only with Y=2; Busy=0 the following cycle.
- Load R=8'h81; hold Ready=0 for 4 cycles -> Valid=1, Y=7, Last=0 stable throughout; then Ready=1 -> Y=7, then Y=0 with Last=1.
- Load R=8'h00 -> Z=1 for exactly one cycle; Count=0; Valid and Busy never assert.
- Load R=8'hF0; during emission drive Load=1 with R=8'h0F, including on the final-transfer cycle -> output sequence is only 7,6,5,4; Busy drops afterward; Count stays 4.
- Load R=8'hFF (Ready=1) -> Count=8 (4'b1000); Y=7 down to 0; Last=1 on Y=0. Repeat and drop Resetn after 2 transfers -> all outputs 0 immediately, without a clock edge; after release, Load R=8'h01 -> Y=0, Last=1, Count=1.
- Back-to-back vectors: Load R=8'h02; Load again the cycle after Busy falls with R=8'h40 -> Y=1, then one idle cycle, then Y=6.
